// File: rtl/fp_mul_seq.sv
// FP32 multiply stage of the MAC: shift-add mantissa product,
// one partial product per cycle, truncating, denormals flushed.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        valid,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [1:0]  state;
  logic        sign;
  logic [9:0]  exp_tmp;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [47:0] acc;
  logic [4:0]  cnt;
  logic [1:0]  spec;

  logic a_max, a_min, a_fz;
  logic b_max, b_min, b_fz;
  logic a_nan, a_inf, b_nan, b_inf;
  logic [1:0]  spec_in;
  logic [9:0]  exp_in;
  logic [47:0] pp;
  logic [9:0]  exp_n;
  logic [22:0] frac_n;
  logic [31:0] res;

  assign a_max = &a[30:23];
  assign a_min = ~|a[30:23];
  assign a_fz  = ~|a[22:0];
  assign b_max = &b[30:23];
  assign b_min = ~|b[30:23];
  assign b_fz  = ~|b[22:0];

  assign a_nan = a_max & ~a_fz;
  assign a_inf = a_max & a_fz;
  assign b_nan = b_max & ~b_fz;
  assign b_inf = b_max & b_fz;

  // zero exponent counts as zero: denormal inputs are flushed
  always_comb begin
    spec_in = SP_NONE;
    if (a_nan | b_nan | (a_inf & b_min) | (b_inf & a_min))
      spec_in = SP_NAN;
    else if (a_inf | b_inf)
      spec_in = SP_INF;
    else if (a_min | b_min)
      spec_in = SP_ZERO;
  end

  assign exp_in = {2'b00, a[30:23]}
                + {2'b00, b[30:23]}
                - 10'd127;

  assign pp = mb[cnt] ? ({24'd0, ma} << cnt) : 48'd0;

  assign exp_n  = acc[47] ? exp_tmp + 10'd1 : exp_tmp;
  assign frac_n = acc[47] ? acc[46:24] : acc[45:23];

  always_comb begin
    res = {sign, exp_n[7:0], frac_n};
    if ($signed(exp_n) >= $signed(10'sd255))
      res = {sign, 8'hFF, 23'd0};
    else if ($signed(exp_n) <= $signed(10'sd0))
      res = {sign, 31'd0};
    if (spec == SP_NAN)
      res = QNAN;
    else if (spec == SP_INF)
      res = {sign, 8'hFF, 23'd0};
    else if (spec == SP_ZERO)
      res = {sign, 31'd0};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sign    <= 1'b0;
      exp_tmp <= 10'd0;
      ma      <= 24'd0;
      mb      <= 24'd0;
      acc     <= 48'd0;
      cnt     <= 5'd0;
      spec    <= SP_NONE;
      product <= 32'd0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign    <= a[31] ^ b[31];
            exp_tmp <= exp_in;
            ma      <= {1'b1, a[22:0]};
            mb      <= {1'b1, b[22:0]};
            acc     <= 48'd0;
            cnt     <= 5'd0;
            spec    <= spec_in;
            state   <= MUL;
          end
        end
        MUL: begin
          acc <= acc + pp;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23)
            state <= NORM;
        end
        NORM: begin
          product <= res;
          valid   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: arithmetic reference model with cycle
// timing, per-cycle compare, plus directed literal vectors.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] product;
  logic        valid;
  logic        busy;

  int checks = 0;
  int passed = 0;
  bit mon = 1'b0;

  fp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b),
    .product(product), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    int ex, ey, e;
    longint unsigned p, q;
    logic s;
    logic [22:0] f;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xi && yz) || (yi && xz))
      return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p = {40'd0, 1'b1, x[22:0]};
    q = {40'd0, 1'b1, y[22:0]};
    p = p * q;
    e = ex + ey - 127;
    if ((p >> 47) != 0) begin
      e++;
      f = 23'(p >> 24);
    end else begin
      f = 23'(p >> 23);
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), f};
  endfunction

  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_prod = 32'd0;
  logic [31:0] m_pend = 32'd0;

  // model: an accepted op completes 25 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      m_prod  = 32'd0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_prod  = m_pend;
        end
      end else if (start) begin
        m_cnt  = 25;
        m_pend = ref_mul(a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("cyc_valid", 32'(valid), 32'(m_valid));
      chk("cyc_busy", 32'(busy), 32'(m_cnt > 0));
      chk("cyc_product", product, m_prod);
    end
  end

  task automatic wait_valid(output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input string nm,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] want);
    int n, bc;
    chk({nm, "_model"}, ref_mul(x, y), want);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_valid(n, bc);
    chk({nm, "_lat"}, n, 25);
    chk({nm, "_busy"}, bc, 25);
    chk({nm, "_prod"}, product, want);
  endtask

  initial begin
    int n, bc, vc;
    repeat (3) @(negedge clk);
    chk("rst_product", product, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    mon = 1'b1;

    run_op("mul_1p5x2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    run_op("sign", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    run_op("zero", 32'h0000_0000, 32'h42F6_0000, 32'h0000_0000);
    run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    run_op("infxzero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("ninf", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    run_op("nan", 32'h4000_0000, 32'h7FC0_1234, 32'h7FC0_0000);
    run_op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    run_op("one_x_max", 32'h3F80_0000, 32'h3FFF_FFFF, 32'h3FFF_FFFF);
    run_op("trunc", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
    run_op("norm_hi", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);

    // start during the valid cycle is accepted
    a = 32'hC040_0000; b = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n, bc);
    chk("b2b_lat", n, 25);
    chk("b2b_prod", product, 32'hC110_0000);

    // starts while busy are dropped
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'h3F80_0000;
    vc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 12);
      if (valid) vc++;
    end
    start = 1'b0;
    chk("ignore_vcount", vc, 1);
    chk("ignore_prod", product, 32'h4110_0000);

    // asynchronous reset in the middle of MUL
    @(negedge clk);
    a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_product", product, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vc = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid) vc++;
    end
    chk("abort_novalid", vc, 0);
    run_op("post_rst", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);

    repeat (3) @(negedge clk);
    mon = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
